// File: rtl/alu_op_scheduler_pkg.sv
// Shared opcode and state constants for the ALU scheduler and the ALU select logic.
package alu_op_scheduler_pkg;

    localparam int OP_W  = 4;
    localparam int CNT_W = 4;

    typedef logic [OP_W-1:0] opcode_t;
    typedef logic [1:0]      state_t;

    localparam opcode_t OP_NOP = 4'd0;
    localparam opcode_t OP_ADD = 4'd1;
    localparam opcode_t OP_SUB = 4'd2;
    localparam opcode_t OP_AND = 4'd3;
    localparam opcode_t OP_OR  = 4'd4;
    localparam opcode_t OP_XOR = 4'd5;
    localparam opcode_t OP_INV = 4'd6;
    localparam opcode_t OP_SHL = 4'd7;
    localparam opcode_t OP_SHR = 4'd8;
    localparam opcode_t OP_MAX = 4'd8;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    function automatic logic op_illegal(input opcode_t op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Request, ALU and response signals of the ALU scheduler; slave is the scheduler side.
interface alu_op_scheduler_if #(parameter int WIDTH = 8);
    import alu_op_scheduler_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    opcode_t          req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    opcode_t          req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    opcode_t          alu_opS;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;
    logic             resp_err;
    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, resp_ready,
        output req0_ready, req1_ready,
        output alu_opS, alu_a, alu_b,
        output resp_valid, resp_id, resp_result, resp_zero, resp_err, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_opS, alu_a, alu_b,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_err, busy
    );

endinterface

// File: rtl/alu_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters: arbitrate, hold operands for ALU_LAT cycles,
// then present the captured result until the consumer takes it.
module alu_op_scheduler
    import alu_op_scheduler_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input logic              clk,
    input logic              rst,
    alu_op_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LAT - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    opcode_t           op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              id_q, id_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              zero_q, zero_d;

    logic [1:0]        grant;
    opcode_t           sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

    // Grants are suppressed outside IDLE and while reset is asserted.
    rr_arbiter2 u_arb (
        .req        ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant_q),
        .en         ((state_q == ST_IDLE) && !rst),
        .grant      (grant)
    );

    assign sel_op = grant[1] ? bus.req1_op : bus.req0_op;
    assign sel_a  = grant[1] ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant[1] ? bus.req1_b  : bus.req0_b;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        err_d        = err_q;
        res_d        = res_q;
        zero_d       = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    id_d    = grant[1];
                    err_d   = op_illegal(sel_op);
                    op_d    = op_illegal(sel_op) ? OP_NOP : sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    cnt_d   = LAT_M1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    res_d   = err_q ? '0 : bus.alu_result;
                    zero_d  = (res_d == '0);
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                // Priority only moves once the response has actually been consumed.
                if (bus.resp_ready) begin
                    last_grant_d = id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            op_q         <= OP_NOP;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            res_q        <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            err_q        <= err_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
        end
    end

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.alu_opS     = (state_q == ST_WAIT) ? op_q : OP_NOP;
    assign bus.alu_a       = (state_q == ST_WAIT) ? a_q  : '0;
    assign bus.alu_b       = (state_q == ST_WAIT) ? b_q  : '0;
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_id     = id_q;
    assign bus.resp_result = res_q;
    assign bus.resp_zero   = zero_q;
    assign bus.resp_err    = err_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with ALU_LAT=1 and ALU_LAT=3 instances and response scoreboards.
module tb_alu_op_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [10:0] exp1_q[$];
    logic [10:0] exp3_q[$];

    alu_op_scheduler_if #(.WIDTH(8)) if1 ();
    alu_op_scheduler_if #(.WIDTH(8)) if3 ();

    alu_op_scheduler #(.WIDTH(8), .ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    alu_op_scheduler #(.WIDTH(8), .ALU_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return ~a;
            4'd7:    return a << 1;
            4'd8:    return a >> 1;
            default: return 8'h00;
        endcase
    endfunction

    // ALU models: combinational for latency 1, two register stages for latency 3.
    logic [7:0] alu3_p1, alu3_p2;
    assign if1.alu_result = alu_f(if1.alu_opS, if1.alu_a, if1.alu_b);
    always @(posedge clk) begin
        alu3_p1 <= alu_f(if3.alu_opS, if3.alu_a, if3.alu_b);
        alu3_p2 <= alu3_p1;
    end
    assign if3.alu_result = alu3_p2;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [10:0] pack(input logic id, input logic err, input logic zero, input logic [7:0] res);
        return {id, err, zero, res};
    endfunction

    task automatic mon_cmp(input string tag, input logic [10:0] e, input logic id, input logic err,
                           input logic zero, input logic [7:0] res);
        check({tag, "_id"},     {31'd0, id},   {31'd0, e[10]});
        check({tag, "_err"},    {31'd0, err},  {31'd0, e[9]});
        check({tag, "_zero"},   {31'd0, zero}, {31'd0, e[8]});
        check({tag, "_result"}, {24'd0, res},  {24'd0, e[7:0]});
    endtask

    always @(negedge clk) begin
        if (!rst && if1.resp_valid && if1.resp_ready) begin
            if (exp1_q.size() == 0) check("mon1_unexpected_resp", 32'd1, 32'd0);
            else mon_cmp("mon1", exp1_q.pop_front(), if1.resp_id, if1.resp_err, if1.resp_zero, if1.resp_result);
        end
        if (!rst && if3.resp_valid && if3.resp_ready) begin
            if (exp3_q.size() == 0) check("mon3_unexpected_resp", 32'd1, 32'd0);
            else mon_cmp("mon3", exp3_q.pop_front(), if3.resp_id, if3.resp_err, if3.resp_zero, if3.resp_result);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_empty(input int which);
        for (int t = 0; t < 20; t++) begin
            if ((which == 1 ? exp1_q.size() : exp3_q.size()) == 0) break;
            step();
        end
        check(which == 1 ? "drain1" : "drain3", which == 1 ? exp1_q.size() : exp3_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int last;
        rst = 1'b1;
        if1.req0_valid = 1'b1; if1.req0_op = 4'd1; if1.req0_a = 8'h05; if1.req0_b = 8'h03;
        if1.req1_valid = 1'b0; if1.req1_op = 4'd0; if1.req1_a = 8'h00; if1.req1_b = 8'h00;
        if1.resp_ready = 1'b1;
        if3.req0_valid = 1'b0; if3.req0_op = 4'd0; if3.req0_a = 8'h00; if3.req0_b = 8'h00;
        if3.req1_valid = 1'b0; if3.req1_op = 4'd0; if3.req1_a = 8'h00; if3.req1_b = 8'h00;
        if3.resp_ready = 1'b0;
        step(); step();
        sample();
        check("rst_ready0", if1.req0_ready, 0);
        check("rst_resp_valid", if1.resp_valid, 0);
        check("rst_busy", if1.busy, 0);
        check("rst_alu_opS", if1.alu_opS, 0);

        // Test 1: single ADD, latency 1
        step(); rst = 1'b0;
        sample();
        check("t1_ready0", if1.req0_ready, 1);
        check("t1_ready1", if1.req1_ready, 0);
        check("t1_idle_opS", if1.alu_opS, 0);
        exp1_q.push_back(pack(1'b0, 1'b0, 1'b0, 8'h08));
        step(); if1.req0_valid = 1'b0;
        sample();
        check("t1_opS", if1.alu_opS, 1);
        check("t1_a", if1.alu_a, 8'h05);
        check("t1_b", if1.alu_b, 8'h03);
        check("t1_busy", if1.busy, 1);
        check("t1_wait_ready0", if1.req0_ready, 0);
        step();
        sample();
        check("t1_resp_valid", if1.resp_valid, 1);
        check("t1_resp_opS", if1.alu_opS, 0);
        step();
        sample();
        check("t1_back_idle", if1.busy, 0);
        wait_empty(1);

        // Test 2: both requesters continuously after reset
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        if1.req0_valid = 1'b1; if1.req0_op = 4'd2; if1.req0_a = 8'h10; if1.req0_b = 8'h10;
        if1.req1_valid = 1'b1; if1.req1_op = 4'd2; if1.req1_a = 8'h10; if1.req1_b = 8'h10;
        for (int i = 0; i < 4; i++) exp1_q.push_back(pack(i[0], 1'b0, 1'b1, 8'h00));
        k = 0;
        for (int t = 0; t < 40 && k < 4; t++) begin
            sample();
            if (if1.req0_ready || if1.req1_ready) begin
                check("t2_grant_id", if1.req1_ready, k % 2);
                check("t2_onehot", if1.req0_ready & if1.req1_ready, 0);
                k++;
            end
            step();
            if (k == 4) begin
                if1.req0_valid = 1'b0;
                if1.req1_valid = 1'b0;
            end
        end
        check("t2_grant_count", k, 4);
        wait_empty(1);

        // Test 3: illegal opcode from requester 1
        step();
        if1.req1_valid = 1'b1; if1.req1_op = 4'd12; if1.req1_a = 8'hFF; if1.req1_b = 8'hFF;
        sample();
        check("t3_ready1", if1.req1_ready, 1);
        exp1_q.push_back(pack(1'b1, 1'b1, 1'b1, 8'h00));
        step(); if1.req1_valid = 1'b0;
        sample();
        check("t3_opS_nop", if1.alu_opS, 0);
        check("t3_busy", if1.busy, 1);
        wait_empty(1);

        // Test 5a: reset during WAIT
        step();
        if1.req0_valid = 1'b1; if1.req0_op = 4'd1; if1.req0_a = 8'h01; if1.req0_b = 8'h01;
        sample();
        check("t5a_ready0", if1.req0_ready, 1);
        step(); if1.req0_valid = 1'b0; rst = 1'b1;
        sample();
        check("t5a_in_wait", if1.busy, 1);
        check("t5a_rst_ready0", if1.req0_ready, 0);
        step(); rst = 1'b0;
        if1.req0_valid = 1'b1;
        if1.req1_valid = 1'b1; if1.req1_op = 4'd3; if1.req1_a = 8'hF0; if1.req1_b = 8'h3C;
        sample();
        check("t5a_resp_valid", if1.resp_valid, 0);
        check("t5a_opS", if1.alu_opS, 0);
        check("t5a_busy", if1.busy, 0);
        check("t5a_ready0", if1.req0_ready, 1);
        check("t5a_ready1", if1.req1_ready, 0);
        exp1_q.push_back(pack(1'b0, 1'b0, 1'b0, 8'h02));
        step(); if1.req0_valid = 1'b0; if1.req1_valid = 1'b0;
        wait_empty(1);

        // Test 5b: reset during RESP after a requester-0 handshake
        step(); if1.resp_ready = 1'b0;
        if1.req1_valid = 1'b1;
        sample();
        check("t5b_ready1", if1.req1_ready, 1);
        step(); if1.req1_valid = 1'b0;
        step();
        sample();
        check("t5b_resp_valid", if1.resp_valid, 1);
        check("t5b_resp_result", if1.resp_result, 8'h30);
        check("t5b_resp_id", if1.resp_id, 1);
        step(); rst = 1'b1;
        step(); rst = 1'b0; if1.resp_ready = 1'b1;
        if1.req0_valid = 1'b1; if1.req0_op = 4'd5; if1.req0_a = 8'hAA; if1.req0_b = 8'hFF;
        if1.req1_valid = 1'b1;
        sample();
        check("t5b_resp_dropped", if1.resp_valid, 0);
        check("t5b_busy", if1.busy, 0);
        check("t5b_opS", if1.alu_opS, 0);
        check("t5b_ready0", if1.req0_ready, 1);
        check("t5b_ready1", if1.req1_ready, 0);
        exp1_q.push_back(pack(1'b0, 1'b0, 1'b0, 8'h55));
        step(); if1.req0_valid = 1'b0; if1.req1_valid = 1'b0;
        wait_empty(1);

        // Test 6: requester 1 alone, back-to-back
        step();
        if1.req1_valid = 1'b1; if1.req1_op = 4'd4; if1.req1_a = 8'h0F; if1.req1_b = 8'hF0;
        for (int i = 0; i < 3; i++) exp1_q.push_back(pack(1'b1, 1'b0, 1'b0, 8'hFF));
        k = 0;
        last = 0;
        for (int t = 0; t < 30 && k < 3; t++) begin
            sample();
            check("t6_ready0_low", if1.req0_ready, 0);
            if (if1.req1_ready) begin
                if (k > 0) check("t6_accept_gap", cyc - last, 3);
                last = cyc;
                k++;
            end
            step();
            if (k == 3) if1.req1_valid = 1'b0;
        end
        check("t6_accept_count", k, 3);
        wait_empty(1);

        // Test 4: ALU_LAT=3 with stalled consumer
        step();
        if3.req0_valid = 1'b1; if3.req0_op = 4'd7; if3.req0_a = 8'h81; if3.req0_b = 8'h00;
        sample();
        check("t4_ready0", if3.req0_ready, 1);
        exp3_q.push_back(pack(1'b0, 1'b0, 1'b0, 8'h02));
        step(); if3.req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t4_opS", if3.alu_opS, 7);
            check("t4_a", if3.alu_a, 8'h81);
            check("t4_no_resp", if3.resp_valid, 0);
            step();
        end
        if3.req0_valid = 1'b1; if3.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("t4_hold_valid", if3.resp_valid, 1);
            check("t4_hold_result", if3.resp_result, 8'h02);
            check("t4_hold_id", if3.resp_id, 0);
            check("t4_hold_zero", if3.resp_zero, 0);
            check("t4_hold_ready0", if3.req0_ready, 0);
            check("t4_hold_ready1", if3.req1_ready, 0);
            check("t4_hold_busy", if3.busy, 1);
            check("t4_hold_opS", if3.alu_opS, 0);
            step();
        end
        if3.resp_ready = 1'b1; if3.req0_valid = 1'b0; if3.req1_valid = 1'b0;
        sample();
        step();
        sample();
        check("t4_back_idle", if3.busy, 0);
        check("t4_resp_cleared", if3.resp_valid, 0);
        wait_empty(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares one 8-bit ALU (opcode-select result mux, opS 0..8) between two requesters.
- Round-robin arbitration; valid/ready handshake on request and response sides.
- Drives ALU opcode/operands, waits a fixed latency, then returns the captured result with zero/error flags.
- Sits between the instruction/control front end and the ALU datapath.

Parameters:
- WIDTH, 8, operand/result width.
- ALU_LAT, 1, cycles from operands driven to alu_result valid; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has a command
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_op  in  4  requester 0 opcode
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- alu_opS  out  4  opcode to ALU select
- alu_a  out  WIDTH  operand A to ALU
- alu_b  out  WIDTH  operand B to ALU
- alu_result  in  WIDTH  ALU result
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that owns the response
- resp_result  out  WIDTH  captured result
- resp_zero  out  1  resp_result == 0
- resp_err  out  1  opcode was illegal (9..15)
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (rst=1 at a clk edge) from any state, including mid-WAIT or RESP: state=IDLE, last_grant=1 (requester 0 wins first), wait counter=0, operand/opcode/result regs=0, resp_valid=0, resp_id=0, resp_zero=0, resp_err=0. Any pending response is dropped.
- IDLE arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready=1 only for the granted requester, only in IDLE. Ready is 0 in WAIT and RESP and during rst.
- Acceptance (IDLE, granted valid):
  - Latch op/a/b and id; counter=ALU_LAT-1; go to WAIT.
  - If op>8: latched opcode=0 and err=1. The command still takes full timing.
- WAIT:
  - alu_opS/alu_a/alu_b driven from latched regs, stable for the whole state.
  - Outside WAIT they are 0 (NOP, zero operands).
  - Counter decrements each cycle. In the cycle with counter==0, sample alu_result into resp_result (forced 0 if err), compute resp_zero, go to RESP.
  - Minimum WAIT length is ALU_LAT cycles.
- RESP:
  - resp_valid=1; resp_id/result/zero/err held stable until resp_ready=1.
  - On handshake: last_grant=resp_id, go to IDLE.
  - No new command is accepted in the handshake cycle; the next accept is possible the following cycle.
- Latency: accept edge to resp_valid = ALU_LAT+1 cycles. Peak throughput = one op per ALU_LAT+2 cycles.
- Priority update happens only on the response handshake, not on acceptance.
- Requester deasserting valid while not granted is legal; no state is kept for it.
- Arithmetic: no width change; the scheduler passes the ALU result unmodified. Carry/overflow are out of scope.

Decomposition:
- Shared package holds:
  - Opcode constants OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_INV=6, OP_SHL=7, OP_SHR=8, OP_MAX=8.
  - State encoding IDLE/WAIT/RESP.
  - These are shared with the ALU select logic.
- One sub-module: rr_arbiter2.
  - Inputs: req[1:0], last_grant, en.
  - Output: one-hot grant.
  - Purely combinational.
- Counter, FSM and response regs stay in alu_op_scheduler.

Test Plan:
1. Reset, ALU_LAT=1. req0 op=1 a=8'h05 b=8'h03 -> req0_ready=1 in the first IDLE cycle; alu_opS=1, alu_a=05, alu_b=03 for one cycle; resp_valid 2 cycles after accept with result=08, id=0, zero=0, err=0.
2. Both valid continuously after reset, op=2, a=10, b=10 -> grants alternate 0,1,0,1; every response has result=00 and zero=1; no requester is accepted twice in a row.
3. req1 op=4'd12 a=FF b=FF -> accepted; alu_opS=0 throughout; resp_result=00, err=1, zero=1, id=1.
4. ALU_LAT=3, req0 op=7 a=8'h81 -> alu_opS=7 held 3 cycles; resp_valid on cycle 4 after accept; resp_ready held 0 for 5 cycles -> outputs stable, req0/req1 ready stay 0, busy=1.
5. rst pulsed for 1 cycle during WAIT, and separately during RESP -> next cycle: resp_valid=0, alu_opS=0, busy=0, state IDLE, req0 wins if both valid.
6. Single requester req1 valid back-to-back -> accepted every ALU_LAT+2 cycles with no idle starvation; req0_ready never asserts.
